// File: rtl/gn_mdl_clkdiv_gen_if.sv
// Configuration request channel for the multi-channel clock divider.
// The master issues {ch, div, en} requests; the slave answers with ready/err.
interface gn_mdl_clkdiv_gen_if #(
    parameter int P_N_CH  = 4,
    parameter int P_W_DIV = 8
);
    localparam int W_CH = (P_N_CH > 1) ? $clog2(P_N_CH) : 1;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [W_CH-1:0]    cfg_ch;
    logic [P_W_DIV-1:0] cfg_div;
    logic               cfg_en;
    logic               cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        output cfg_en,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_en,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/gn_mdl_clkdiv_gen.sv
// Multi-channel clock divider / tick generator with glitch-free runtime
// reconfiguration at period boundaries and a global phase sync.
module gn_mdl_clkdiv_gen #(
    parameter int P_N_CH    = 4,
    parameter int P_W_DIV   = 8,
    parameter int P_DIV_RST = 2
) (
    input  logic              clk,
    input  logic              rst,
    gn_mdl_clkdiv_gen_if.slave cfg,
    input  logic              sync_req,
    output logic [P_N_CH-1:0] div_clk,
    output logic [P_N_CH-1:0] tick,
    output logic [P_N_CH-1:0] ch_active
);
    localparam int W_CH = (P_N_CH > 1) ? $clog2(P_N_CH) : 1;

    typedef logic [P_W_DIV-1:0] div_t;

    logic [P_N_CH-1:0] pend_v;
    logic              ch_ok;
    logic              sel_pend;
    logic              acc;
    logic              bad;
    logic              good;
    logic              err_q;

    // Out-of-range channel indices are accepted and rejected via cfg_err.
    assign ch_ok    = int'(cfg.cfg_ch) < P_N_CH;
    assign sel_pend = ch_ok ? pend_v[cfg.cfg_ch] : 1'b0;

    assign cfg.cfg_ready = !rst && !sel_pend;
    assign acc  = cfg.cfg_valid && cfg.cfg_ready;
    assign bad  = acc && (!ch_ok ||
                  (cfg.cfg_en && (cfg.cfg_div < div_t'(2))));
    assign good = acc && !bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bad;
        end
    end

    assign cfg.cfg_err = err_q;

    for (genvar i = 0; i < P_N_CH; i++) begin : g_ch
        div_t cnt_q;
        div_t d_q;
        div_t pd_q;
        div_t cnt_n;
        div_t d_n;
        div_t nd;
        logic act_q;
        logic act_n;
        logic pend_q;
        logic pe_q;
        logic clk_q;
        logic tick_q;
        logic take;
        logic wrap;
        logic bnd;
        logic upd;
        logic ne;

        assign take = good && (cfg.cfg_ch == W_CH'(i));
        assign wrap = act_q && (cnt_q == d_q - div_t'(1));
        // Boundary: any point where a new period may begin or config lands.
        assign bnd  = sync_req || !act_q || wrap;
        // A request accepted in a sync cycle is folded into that sync.
        assign upd  = pend_q || (take && sync_req);
        assign ne   = pend_q ? pe_q : cfg.cfg_en;
        assign nd   = pend_q ? pd_q : cfg.cfg_div;

        always_comb begin
            cnt_n = cnt_q + div_t'(1);
            d_n   = d_q;
            act_n = act_q;
            if (bnd) begin
                cnt_n = '0;
                if (upd) begin
                    act_n = ne;
                    if (ne) begin
                        d_n = nd;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                d_q    <= div_t'(P_DIV_RST);
                pd_q   <= '0;
                act_q  <= 1'b0;
                pend_q <= 1'b0;
                pe_q   <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_n;
                d_q    <= d_n;
                act_q  <= act_n;
                clk_q  <= act_n && (cnt_n < (d_n >> 1));
                tick_q <= act_n && (cnt_n == d_n - div_t'(1));
                if (bnd && upd) begin
                    pend_q <= 1'b0;
                end
                if (take && !sync_req) begin
                    pend_q <= 1'b1;
                    pe_q   <= cfg.cfg_en;
                    pd_q   <= cfg.cfg_div;
                end
            end
        end

        assign pend_v[i]    = pend_q;
        assign div_clk[i]   = clk_q;
        assign tick[i]      = tick_q;
        assign ch_active[i] = act_q;
    end
endmodule

// File: tb/tb_gn_mdl_clkdiv_gen.sv
// Bench for gn_mdl_clkdiv_gen: constant vector table, directed corner
// sequences and random traffic against a period-based reference model.
module tb_gn_mdl_clkdiv_gen;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DR = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sync_req = 1'b0;
    logic [N-1:0] div_clk;
    logic [N-1:0] tick;
    logic [N-1:0] ch_active;

    gn_mdl_clkdiv_gen_if #(.P_N_CH(N), .P_W_DIV(W)) cf ();

    gn_mdl_clkdiv_gen #(
        .P_N_CH(N), .P_W_DIV(W), .P_DIV_RST(DR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg(cf),
        .sync_req(sync_req),
        .div_clk(div_clk),
        .tick(tick),
        .ch_active(ch_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [1:0]   ch;
        logic [7:0]   d;
        logic         en;
        logic [N-1:0] act;
        logic [N-1:0] dclk;
        logic [N-1:0] tk;
        logic         err;
    } vec_t;

    vec_t tbl[19];
    vec_t z;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: each active channel remembers when its current period began.
    bit m_act[N];
    int m_d[N];
    int m_start[N];
    bit m_pend[N];
    bit m_pe[N];
    int m_pd[N];
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input int ch, input int d,
                         input logic en, input logic s);
        cf.cfg_valid = v;
        cf.cfg_ch    = 2'(ch);
        cf.cfg_div   = 8'(d);
        cf.cfg_en    = en;
        sync_req     = s;
    endtask

    function automatic logic [N-1:0] m_vec(input int kind);
        logic [N-1:0] r;
        int p;
        r = '0;
        for (int c = 0; c < N; c++) begin
            p = cyc - m_start[c];
            if (m_act[c]) begin
                if (kind == 0) r[c] = 1'b1;
                if (kind == 1) r[c] = (p < m_d[c] / 2);
                if (kind == 2) r[c] = (p == m_d[c] - 1);
            end
        end
        return r;
    endfunction

    task automatic model_step();
        bit acc, take, bnd, upd, ne;
        int ch, nd;
        cyc++;
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                m_act[c]  = 0;
                m_d[c]    = DR;
                m_pend[c] = 0;
                m_start[c] = cyc;
            end
            m_err = 0;
            return;
        end
        ch    = int'(cf.cfg_ch);
        acc   = cf.cfg_valid && !m_pend[ch];
        m_err = acc && cf.cfg_en && (int'(cf.cfg_div) < 2);
        for (int c = 0; c < N; c++) begin
            take = acc && !m_err && (ch == c);
            bnd  = sync_req || !m_act[c] ||
                   (cyc - 1 - m_start[c] == m_d[c] - 1);
            upd  = m_pend[c] || (take && sync_req);
            if (bnd && upd) begin
                ne = m_pend[c] ? m_pe[c] : cf.cfg_en;
                nd = m_pend[c] ? m_pd[c] : int'(cf.cfg_div);
                m_act[c] = ne;
                if (ne) m_d[c] = nd;
                m_pend[c] = 0;
            end
            if (bnd && m_act[c]) m_start[c] = cyc;
            if (take && !sync_req) begin
                m_pend[c] = 1;
                m_pe[c]   = cf.cfg_en;
                m_pd[c]   = int'(cf.cfg_div);
            end
        end
    endtask

    task automatic cycle(input bit tbl_mode, input vec_t e);
        @(negedge clk);
        chk("cfg_ready", cf.cfg_ready,
            !rst && !m_pend[int'(cf.cfg_ch)]);
        @(posedge clk);
        model_step();
        #1;
        if (tbl_mode) begin
            chk("tbl_active", ch_active, e.act);
            chk("tbl_divclk", div_clk, e.dclk);
            chk("tbl_tick", tick, e.tk);
            chk("tbl_err", cf.cfg_err, e.err);
        end else begin
            chk("ch_active", ch_active, m_vec(0));
            chk("div_clk", div_clk, m_vec(1));
            chk("tick", tick, m_vec(2));
            chk("cfg_err", cf.cfg_err, m_err);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 0, 0, 0);
            cycle(0, z);
        end
    endtask

    task automatic wait_pos(input int c, input int p);
        int k;
        for (k = 0; k < 300; k++) begin
            if (m_act[c] && (cyc - m_start[c] == p)) break;
            drive(0, 0, 0, 0, 0);
            cycle(0, z);
        end
        chk("wait_pos_timeout", k < 300, 1);
    endtask

    initial begin
        z = '{v:0, ch:0, d:0, en:0, act:0, dclk:0, tk:0, err:0};
        tbl[0]  = '{1, 0, 4, 1, 4'h0, 4'h0, 4'h0, 0};
        tbl[1]  = '{0, 0, 0, 0, 4'h1, 4'h1, 4'h0, 0};
        tbl[2]  = '{0, 0, 0, 0, 4'h1, 4'h1, 4'h0, 0};
        tbl[3]  = '{0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 0};
        tbl[4]  = '{0, 0, 0, 0, 4'h1, 4'h0, 4'h1, 0};
        tbl[5]  = '{0, 0, 0, 0, 4'h1, 4'h1, 4'h0, 0};
        tbl[6]  = '{0, 0, 0, 0, 4'h1, 4'h1, 4'h0, 0};
        tbl[7]  = '{0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 0};
        tbl[8]  = '{0, 0, 0, 0, 4'h1, 4'h0, 4'h1, 0};
        tbl[9]  = '{1, 2, 1, 1, 4'h1, 4'h1, 4'h0, 1};
        tbl[10] = '{1, 2, 0, 1, 4'h1, 4'h1, 4'h0, 1};
        tbl[11] = '{0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 0};
        tbl[12] = '{0, 0, 0, 0, 4'h1, 4'h0, 4'h1, 0};
        tbl[13] = '{1, 2, 0, 0, 4'h1, 4'h1, 4'h0, 0};
        tbl[14] = '{0, 0, 0, 0, 4'h1, 4'h1, 4'h0, 0};
        tbl[15] = '{1, 3, 3, 1, 4'h1, 4'h0, 4'h0, 0};
        tbl[16] = '{0, 0, 0, 0, 4'h9, 4'h8, 4'h1, 0};
        tbl[17] = '{0, 0, 0, 0, 4'h9, 4'h1, 4'h0, 0};
        tbl[18] = '{0, 0, 0, 0, 4'h9, 4'h1, 4'h8, 0};

        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        cycle(0, z);
        cycle(0, z);
        chk("rst_active", ch_active, 0);
        chk("rst_divclk", div_clk, 0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, int'(tbl[i].ch), int'(tbl[i].d),
                  tbl[i].en, 0);
            cycle(1, tbl[i]);
        end

        // Odd ratio on ch1.
        drive(1, 1, 5, 1, 0);
        cycle(0, z);
        idle(12);

        // Ratio change mid-period on ch0, second write blocked until wrap.
        wait_pos(0, 1);
        drive(1, 0, 6, 1, 0);
        cycle(0, z);
        drive(1, 0, 3, 1, 0);
        cycle(0, z);
        drive(1, 3, 2, 1, 0);
        cycle(0, z);
        idle(16);

        // Phase realignment.
        drive(1, 0, 4, 1, 0);
        cycle(0, z);
        drive(1, 1, 6, 1, 0);
        cycle(0, z);
        idle(9);
        drive(0, 0, 0, 0, 1);
        cycle(0, z);
        chk("sync_clk01", div_clk[1:0], 2'b11);
        chk("sync_tick", tick, 0);
        idle(8);

        // Disable at start of high phase, then reset mid-period.
        wait_pos(0, 0);
        drive(1, 0, 0, 0, 0);
        cycle(0, z);
        idle(6);
        rst = 1'b1;
        drive(1, 1, 7, 1, 0);
        cycle(0, z);
        rst = 1'b0;
        chk("rst_mid_active", ch_active, 0);
        chk("rst_mid_divclk", div_clk, 0);
        chk("rst_mid_tick", tick, 0);
        idle(3);

        for (int i = 0; i < 700; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 3,
                  $urandom_range(0, N - 1),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                              : $urandom_range(0, 9),
                  $urandom_range(0, 9) < 8,
                  $urandom_range(0, 99) < 3);
            cycle(0, z);
        end
        rst = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
